// File: rtl/cache_pkg.sv
// Shared cache definitions: address-field index helpers (identical to the cache
// memory's) and the refill engine state encoding.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } refill_state_t;

    function automatic int wwi_start();
        return 2;
    endfunction

    function automatic int wwi_end(input int way_word_count);
        return $clog2(way_word_count) + 1;
    endfunction

    function automatic int set_start(input int way_word_count);
        return wwi_end(way_word_count) + 1;
    endfunction

    function automatic int set_end(input int way_word_count, input int set_count);
        return wwi_end(way_word_count) + $clog2(set_count);
    endfunction

    function automatic int tag_start(input int way_word_count, input int set_count);
        return set_end(way_word_count, set_count) + 1;
    endfunction

    function automatic int tag_idx_size(input int way_word_count, input int set_count);
        return 31 - set_end(way_word_count, set_count);
    endfunction

    function automatic int set_idx_size(input int set_count);
        return $clog2(set_count);
    endfunction

    function automatic int way_idx_size(input int way_count);
        return $clog2(way_count);
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Round-robin victim way selector; advances once per committed refill.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int WAY_COUNT = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 advance_i,
    output logic [way_idx_size(WAY_COUNT)-1:0]   way_o
);

    localparam int WS = way_idx_size(WAY_COUNT);

    logic [WS-1:0] r_way;

    // Power-of-two way count, so the natural wrap gives modulo WAY_COUNT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_way <= {WS{1'b0}};
        end else if (advance_i) begin
            r_way <= r_way + WS'(1);
        end else begin
            r_way <= r_way;
        end
    end

    assign way_o = r_way;

endmodule

// File: rtl/cache_line_refill.sv
// Cache line refill engine: fetches one aligned line over req/gnt/rvalid and
// commits it in a single write cycle. Optional macro: CACHE_REFILL_PERF_CNT_EN.
module cache_line_refill
    import cache_pkg::*;
#(
    parameter int WAY_COUNT      = 2,
    parameter int SET_COUNT      = 64,
    parameter int WAY_WORD_COUNT = 4
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                miss_req_i,
    input  logic [31:0]                                         miss_addr_i,
    output logic                                                miss_ready_o,
    output logic                                                refill_done_o,
    output logic [WAY_WORD_COUNT*32-1:0]                        refill_line_o,
    output logic                                                mem_req_o,
    output logic [31:0]                                         mem_addr_o,
    input  logic                                                mem_gnt_i,
    input  logic                                                mem_rvalid_i,
    input  logic [31:0]                                         mem_rdata_i,
    output logic                                                cache_enable_o,
    output logic                                                cache_write_enable_o,
    output logic [set_idx_size(SET_COUNT)-1:0]                  cache_set_o,
    output logic [way_idx_size(WAY_COUNT)-1:0]                  cache_way_o,
    output logic                                                cache_line_valid_o,
    output logic [tag_idx_size(WAY_WORD_COUNT, SET_COUNT)-1:0]  cache_line_tag_o,
    output logic [WAY_WORD_COUNT*32-1:0]                        cache_line_o,
    output logic [WAY_WORD_COUNT*4-1:0]                         cache_line_be_o
`ifdef CACHE_REFILL_PERF_CNT_EN
    ,
    output logic [31:0]                                         refill_count_o
`endif
);

    localparam int WWI_END      = wwi_end(WAY_WORD_COUNT);
    localparam int SET_END      = set_end(WAY_WORD_COUNT, SET_COUNT);
    localparam int TAG_IDX_SIZE = tag_idx_size(WAY_WORD_COUNT, SET_COUNT);
    localparam int SET_IDX_SIZE = set_idx_size(SET_COUNT);
    localparam int WAY_IDX_SIZE = way_idx_size(WAY_COUNT);
    localparam int CNT_W        = $clog2(WAY_WORD_COUNT) + 1;
    localparam int LINE_W       = WAY_WORD_COUNT * 32;
    localparam logic [31:0] OFFSET_MASK = 32'((64'd1 << (WWI_END + 1)) - 64'd1);

    refill_state_t           r_state;
    logic [31:0]             r_base;
    logic [SET_IDX_SIZE-1:0] r_set;
    logic [TAG_IDX_SIZE-1:0] r_tag;
    logic [CNT_W-1:0]        r_gnt_cnt;
    logic [CNT_W-1:0]        r_rsp_cnt;
    logic [31:0]             r_words [WAY_WORD_COUNT];

    logic                    w_accept;
    logic                    w_req;
    logic                    w_rsp;
    logic                    w_last_rsp;
    logic                    w_commit;
    logic [WAY_IDX_SIZE-1:0] w_way;
    logic [LINE_W-1:0]       w_line;

    assign w_accept   = miss_req_i && (r_state == IDLE);
    assign w_req      = (r_state == FETCH) && (r_gnt_cnt < CNT_W'(WAY_WORD_COUNT));
    // Responses outside FETCH or past the last word are dropped here.
    assign w_rsp      = (r_state == FETCH) && mem_rvalid_i && (r_rsp_cnt < CNT_W'(WAY_WORD_COUNT));
    assign w_last_rsp = w_rsp && (r_rsp_cnt == CNT_W'(WAY_WORD_COUNT - 1));
    assign w_commit   = (r_state == COMMIT);

    // Refill sequencing: capture the miss, count grants/responses, store words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_base    <= 32'd0;
            r_set     <= {SET_IDX_SIZE{1'b0}};
            r_tag     <= {TAG_IDX_SIZE{1'b0}};
            r_gnt_cnt <= {CNT_W{1'b0}};
            r_rsp_cnt <= {CNT_W{1'b0}};
            for (int k = 0; k < WAY_WORD_COUNT; k++) begin
                r_words[k] <= 32'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_base    <= miss_addr_i & ~OFFSET_MASK;
                        r_set     <= miss_addr_i[SET_END:WWI_END+1];
                        r_tag     <= miss_addr_i[31:SET_END+1];
                        r_gnt_cnt <= {CNT_W{1'b0}};
                        r_rsp_cnt <= {CNT_W{1'b0}};
                        r_state   <= FETCH;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                FETCH: begin
                    if (w_req && mem_gnt_i) begin
                        r_gnt_cnt <= r_gnt_cnt + CNT_W'(1);
                    end else begin
                        r_gnt_cnt <= r_gnt_cnt;
                    end
                    if (w_rsp) begin
                        r_words[r_rsp_cnt[CNT_W-2:0]] <= mem_rdata_i;
                        r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
                    end else begin
                        r_rsp_cnt <= r_rsp_cnt;
                    end
                    r_state <= w_last_rsp ? COMMIT : FETCH;
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    cache_victim_sel #(
        .WAY_COUNT (WAY_COUNT)
    ) u_victim_sel (
        .clk       (clk),
        .reset     (reset),
        .advance_i (w_commit),
        .way_o     (w_way)
    );

    // Flatten the word buffer; word k lands at bits [32k+31:32k].
    always_comb begin
        w_line = {LINE_W{1'b0}};
        for (int k = 0; k < WAY_WORD_COUNT; k++) begin
            w_line[k*32 +: 32] = r_words[k];
        end
    end

    assign miss_ready_o         = (r_state == IDLE);
    assign mem_req_o            = w_req;
    assign mem_addr_o           = w_req ? (r_base + (32'(r_gnt_cnt) << 2)) : 32'd0;
    assign refill_done_o        = w_commit;
    assign refill_line_o        = w_commit ? w_line : {LINE_W{1'b0}};
    assign cache_enable_o       = w_commit;
    assign cache_write_enable_o = w_commit;
    assign cache_set_o          = w_commit ? r_set : {SET_IDX_SIZE{1'b0}};
    assign cache_way_o          = w_commit ? w_way : {WAY_IDX_SIZE{1'b0}};
    assign cache_line_valid_o   = w_commit;
    assign cache_line_tag_o     = w_commit ? r_tag : {TAG_IDX_SIZE{1'b0}};
    assign cache_line_o         = w_commit ? w_line : {LINE_W{1'b0}};
    assign cache_line_be_o      = w_commit ? {(WAY_WORD_COUNT*4){1'b1}} : {(WAY_WORD_COUNT*4){1'b0}};

`ifdef CACHE_REFILL_PERF_CNT_EN
    logic [31:0] r_refill_count;

    // Saturating count of committed refills.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refill_count <= 32'd0;
        end else if (w_commit && (r_refill_count != 32'hFFFF_FFFF)) begin
            r_refill_count <= r_refill_count + 32'd1;
        end else begin
            r_refill_count <= r_refill_count;
        end
    end

    assign refill_count_o = r_refill_count;
`endif

endmodule

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Refill engine on the fill side of the set-associative instruction/data cache memory.
- On an accepted miss it reads one aligned line of WAY_WORD_COUNT words from the backing memory over the core's req/gnt/rvalid data interface.
- It assembles the line and commits data, tag and valid bit into the cache memory in a single write cycle, selecting the victim way round-robin.

Parameters:
- WAY_COUNT, 2, ways per set (power of two, >=2)
- SET_COUNT, 64, sets (power of two)
- WAY_WORD_COUNT, 4, 32-bit words per line (power of two, >=2)
- Derived localparams, identical to the cache memory's: WAY_WORD_IDX [WWI_END:2], SET_IDX [SET_END:WWI_END+1], TAG_IDX [31:SET_END+1], TAG_IDX_SIZE, SET_IDX_SIZE, WAY_IDX_SIZE.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- miss_req_i  in  1  miss request
- miss_addr_i  in  32  missing byte address
- miss_ready_o  out  1  engine idle; miss accepted when miss_req_i & miss_ready_o
- refill_done_o  out  1  one-cycle pulse in commit cycle
- refill_line_o  out  WAY_WORD_COUNT*32  assembled line, valid with refill_done_o
- mem_req_o  out  1  backing-memory read request
- mem_addr_o  out  32  word-aligned read address
- mem_gnt_i  in  1  request granted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data
- cache_enable_o  out  1  cache memory enable
- cache_write_enable_o  out  1  write data, tag and valid
- cache_set_o  out  SET_IDX_SIZE  target set
- cache_way_o  out  WAY_IDX_SIZE  victim way
- cache_line_valid_o  out  1  constant 1 during commit
- cache_line_tag_o  out  TAG_IDX_SIZE  tag of the missing address
- cache_line_o  out  WAY_WORD_COUNT*32  line data; word k at bits [32k+31:32k]
- cache_line_be_o  out  WAY_WORD_COUNT*4  all ones during commit

Behaviour:
- Reset (async, active-high): state IDLE; victim counter 0; grant and response counters 0; line buffer 0.
- Reset values of outputs: all outputs 0 except miss_ready_o=1.
- FSM states: IDLE, FETCH, COMMIT.
- IDLE:
  - miss_ready_o=1.
  - On acceptance, register line base (miss_addr_i with bits [WWI_END:0] cleared), set and tag; go to FETCH next cycle.
- FETCH:
  - mem_req_o=1 while grant count < WAY_WORD_COUNT.
  - mem_addr_o = base + 4*grant count.
  - Grant count increments on mem_gnt_i.
  - mem_req_o and mem_addr_o are held stable until granted.
  - Requests are pipelined: the next word may be requested in the cycle after a grant, before any rvalid.
  - On each mem_rvalid_i, mem_rdata_i is stored in line word number (response count), then response count increments.
  - When the final response arrives, go to COMMIT next cycle.
- COMMIT (exactly 1 cycle):
  - cache_enable_o=1, cache_write_enable_o=1, cache_line_be_o all ones, cache_line_valid_o=1.
  - cache_set_o, cache_way_o = victim counter, cache_line_tag_o and cache_line_o driven from registers.
  - refill_done_o=1 and refill_line_o = buffer.
  - Victim counter increments modulo WAY_COUNT; go to IDLE.
- Outside COMMIT: cache_* outputs are 0 and refill_line_o is 0.
- Latency with a zero-wait memory (gnt same cycle, rvalid next cycle), miss accepted at cycle 0:
  - grants at cycles 1..W, rvalid at cycles 2..W+1, COMMIT at cycle W+2, miss_ready_o=1 at W+3.
  - With W=4: commit at cycle 6.
- Boundary conditions:
  - miss_req_i while busy is ignored, not queued.
  - mem_rvalid_i in IDLE or COMMIT, or beyond WAY_WORD_COUNT responses, is ignored.
  - Counters are wide enough to hold WAY_WORD_COUNT without wrap.
  - Address offset addition wraps modulo 2^32.
  - Reset mid-FETCH or mid-COMMIT aborts without a cache write; rvalids arriving after reset deasserts are dropped.

Optional Feature:
- Macro CACHE_REFILL_PERF_CNT_EN.
- Defined: adds output refill_count_o (32 bits), reset 0, incremented in every COMMIT cycle, saturating at 0xFFFFFFFF.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - the index-width localparam functions shared with the cache memory (WWI/SET/TAG start, end and size);
  - typedef enum refill_state_t {IDLE, FETCH, COMMIT}.
- Sub-module cache_victim_sel: round-robin WAY_IDX_SIZE counter with advance_i, async reset to 0, output way_o.

Test Plan:
- Defaults, miss_addr_i=0x0000_1234, zero-wait memory, rdata 0xA0,0xA1,0xA2,0xA3 -> reads at 0x1230/34/38/3C; commit at cycle 6 with set=35, way=0, tag=4, line={A3,A2,A1,A0}, be=16'hFFFF, refill_done_o pulse.
- Same miss, mem_gnt_i held low 3 cycles on word 0 -> mem_req_o stays 1, mem_addr_o stays 0x1230, commit delayed to cycle 9.
- Three back-to-back misses at 0x1234, 0x2234, 0x3234 -> cache_way_o 0, 1, 0; tags 4, 8, 12; all at set 35.
- miss_req_i=1 with addr 0x5000 during FETCH -> ignored; only a single commit occurs, for 0x1234.
- Reset asserted after 2 grants, then 2 stray rvalids -> no cache_write_enable_o, miss_ready_o=1, victim stays 0, next miss commits way 0 with correct data.
- With CACHE_REFILL_PERF_CNT_EN: 5 refills -> refill_count_o=5; reset -> 0.
